bcd2binary_reverse_dabble: RTL and testbench
============================================

BCD2BINARY_REVERSE_DABBLE -- requirements
Module: bcd2binary_reverse_dabble

Interface
REQ-001 SHALL have parameter DIGITS, default 3, number of packed BCD input digits.
REQ-002 SHALL have parameter BIN_W, default 10, binary result width; integrator sets BIN_W = ceil(log2(10^DIGITS)).
REQ-003 SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: in_valid  input  1  packed BCD operand valid.
REQ-007 SHALL have port: in_ready  output  1  block can accept an operand.
REQ-008 SHALL have port: in_bcd  input  4*DIGITS  packed BCD, most significant digit in the top nibble.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port: out_bin  output  BIN_W  binary result.
REQ-012 SHALL have port: out_err  output  1  operand contained a nibble greater than 9.
REQ-013 SHALL have port: busy  output  1  conversion in progress (SHIFT state).

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL accept an operand on a rising edge with in_valid=1 and in_ready=1; in_bcd is captured on that edge only.
REQ-017 On acceptance, the block SHALL load scratch = {in_bcd, BIN_W zeros} and clear the shift counter.
REQ-018 On acceptance with all nibbles <= 9, the FSM SHALL go to SHIFT.
REQ-019 On acceptance with any nibble > 9, the FSM SHALL go directly to DONE with out_err=1 and out_bin=0, performing no shift iterations.
REQ-020 In SHIFT, each clock SHALL perform one iteration: logical right shift of scratch by 1, then subtract 3 from every BCD nibble of the shifted value that is >= 8; all nibble corrections are applied in the same cycle.
REQ-021 SHIFT SHALL last exactly BIN_W cycles; the edge performing the final iteration SHALL move the FSM to DONE and set out_valid=1.
REQ-022 For a valid operand, out_valid SHALL rise exactly BIN_W rising edges after the acceptance edge.
REQ-023 In DONE, out_bin SHALL equal the low BIN_W bits of scratch, and out_err=0 for a valid operand.
REQ-024 In DONE, out_valid, out_bin and out_err SHALL be held stable while out_ready=0.
REQ-025 In DONE, a rising edge with out_ready=1 SHALL complete the transfer, clear out_valid and return the FSM to IDLE, so in_ready=1 in the next cycle; there is no back-to-back overlap.
REQ-026 busy SHALL be 1 only in SHIFT.
REQ-027 in_valid and in_bcd SHALL be ignored in SHIFT and DONE.
REQ-028 Arithmetic SHALL be unsigned with no overflow for legal operands; after the final iteration the BCD field of scratch is zero.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately, without a clock, force: FSM=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, busy=0, scratch=0, counter=0.
REQ-030 A reset asserted mid-conversion SHALL discard the operation; no result is produced for that operand.
REQ-031 After reset deassertion, the first operand SHALL be acceptable on the first rising edge.

Verification
REQ-032 Bench SHALL cover: in_bcd=12'h999, out_ready=1 -> out_valid exactly 10 edges after acceptance, out_bin=10'd999, out_err=0.
REQ-033 Bench SHALL cover: in_bcd=12'h000 -> out_bin=0 after 10 cycles, and in_bcd=12'h255 -> out_bin=10'd255.
REQ-034 Bench SHALL cover: in_bcd=12'h09A -> out_valid on the next edge, out_err=1, out_bin=0, busy never asserted.
REQ-035 Bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid, out_bin and out_err stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-036 Bench SHALL cover: rst_n pulsed low in the 4th SHIFT cycle -> all outputs at reset values asynchronously; no out_valid follows; the next operand 12'h123 converts to 123.
REQ-037 Bench SHALL cover: an exhaustive sweep of 000-999 with random out_ready stalls -> every out_bin equals the decimal value.

Source files
------------

// File: rtl/bcd2binary_reverse_dabble.sv
// Packed BCD to binary converter using reverse double dabble: one shift/correct
// iteration per clock with a valid/ready handshake on both sides.
module bcd2binary_reverse_dabble #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [SCR_W-1:0]   shifted;
    logic [SCR_W-1:0]   dabbled;
    logic [DIGITS-1:0]  nib_bad;

    assign shifted               = scratch_q >> 1;
    assign dabbled[BIN_W-1:0]    = shifted[BIN_W-1:0];

    // A nibble that became >= 8 after the shift held an odd tens carry; undo the +3 bias.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] nib;
        assign nib                          = shifted[BIN_W + 4*gi +: 4];
        assign dabbled[BIN_W + 4*gi +: 4]   = nib[3] ? (nib - 4'd3) : nib;
        assign nib_bad[gi]                  = (in_bcd[4*gi +: 4] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    scratch_d = {in_bcd, {BIN_W{1'b0}}};
                    cnt_d     = '0;
                    err_d     = |nib_bad;
                    state_d   = (|nib_bad) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                scratch_d = dabbled;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result fields read as zero outside DONE so reset and idle values are clean.
    assign out_bin = out_valid ? scratch_q[BIN_W-1:0] : '0;
    assign out_err = out_valid & err_q;

endmodule

// File: tb/tb_bcd2binary_reverse_dabble.sv
// Directed and exhaustive checks for the BCD to binary converter: latency,
// error path, output hold under stall, asynchronous reset and a 000-999 sweep.
module tb_bcd2binary_reverse_dabble;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_bin;
    logic        out_err;
    logic        busy;

    int checks_q = 0;
    int errors_q = 0;

    bcd2binary_reverse_dabble #(
        .DIGITS (3),
        .BIN_W  (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q++;
        if (obs !== exp) begin
            errors_q++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one operand, measures edges from acceptance to out_valid, holds the
    // result for 'stall' cycles with out_ready=0, then completes the transfer.
    task automatic convert(input logic [11:0] bcd, input int exp_lat, input logic [9:0] exp_bin,
                           input logic exp_err, input int stall, input bit verbose);
        int          lat;
        bit          busy_seen;
        logic [9:0]  held_bin;
        logic        held_err;
        @(negedge clk);
        check_eq("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        in_bcd    = bcd;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_bcd    = 12'h777;
        lat       = 0;
        busy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_seen = 1'b1;
            check_eq("in_ready_while_busy", in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", lat, exp_lat);
        check_eq("out_bin", out_bin, exp_bin);
        check_eq("out_err", out_err, exp_err);
        check_eq("busy_in_done", busy, 0);
        if (exp_lat == 0) check_eq("busy_seen_on_error", busy_seen, 0);
        held_bin = out_bin;
        held_err = out_err;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_out_bin", out_bin, held_bin);
            check_eq("hold_out_err", out_err, held_err);
            check_eq("hold_in_ready", in_ready, 0);
        end
        if (stall > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("idle_out_valid", out_valid, 0);
        check_eq("idle_in_ready", in_ready, 1);
        if (verbose)
            $display("xfer bcd=%03h bin=%0d err=%0d lat=%0d stall=%0d", bcd, held_bin, held_err, lat, stall);
    endtask

    initial begin
        int          seen_valid;
        logic [11:0] sweep_bcd;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = 12'h000;
        out_ready = 1'b0;

        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_bin", out_bin, 0);
        check_eq("rst_out_err", out_err, 0);
        check_eq("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(12'h999, 10, 10'd999, 1'b0, 0, 1'b1);
        convert(12'h000, 10, 10'd0,   1'b0, 0, 1'b1);
        convert(12'h255, 10, 10'd255, 1'b0, 0, 1'b1);
        convert(12'h09A, 0,  10'd0,   1'b1, 0, 1'b1);
        convert(12'hF00, 0,  10'd0,   1'b1, 2, 1'b1);
        convert(12'h100, 10, 10'd100, 1'b0, 0, 1'b1);
        convert(12'h808, 10, 10'd808, 1'b0, 5, 1'b1);
        convert(12'h0AA, 0,  10'd0,   1'b1, 5, 1'b1);

        // Reset asserted mid-cycle during the 4th SHIFT cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = 12'h456;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_in_ready", in_ready, 1);
        check_eq("async_rst_out_valid", out_valid, 0);
        check_eq("async_rst_out_bin", out_bin, 0);
        check_eq("async_rst_out_err", out_err, 0);
        check_eq("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        check_eq("no_valid_after_rst", seen_valid, 0);
        $display("xfer bcd=456 discarded by reset");
        convert(12'h123, 10, 10'd123, 1'b0, 0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            sweep_bcd = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            convert(sweep_bcd, 10, 10'(i), 1'b0, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule
